// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone register-bank arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first requester after the last-grant pointer wins.
module rr_arbiter import wb_arb_pkg::*; #(
  parameter  int pNREQ = 2,
  localparam int IW    = idx_width(pNREQ)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [pNREQ-1:0] req,
  input  logic             update,
  output logic [pNREQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW-1:0] last_r;
  logic          found_s;

  // Two passes: indices above the pointer first, then wrap to those at or below it.
  always_comb begin
    found_s = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < pNREQ; j++) begin
      if (!found_s && req[j] && (IW'(j) > last_r)) begin
        found_s = 1'b1;
        gnt_idx = IW'(j);
      end else begin
        found_s = found_s;
      end
    end
    for (int j = 0; j < pNREQ; j++) begin
      if (!found_s && req[j] && (IW'(j) <= last_r)) begin
        found_s = 1'b1;
        gnt_idx = IW'(j);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt = {{(pNREQ-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt = '0;
    end
  end

  // Pointer starts at the last master so master 0 wins the first arbitration.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      last_r <= IW'(pNREQ - 1);
    end else if (update) begin
      last_r <= gnt_idx;
    end
  end

endmodule

// File: rtl/wb_reg_arbiter.sv
// Round-robin Wishbone arbiter sharing one register-bank slave, with locked (HOLD) cycles.
// Optional ack timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_reg_arbiter import wb_arb_pkg::*; #(
  parameter int pNREQ    = 2,
  parameter int pADDRW   = 5,
  parameter int pTIMEOUT = 255
) (
  input  logic                    i_Clk,
  input  logic                    i_ARst,
  input  logic [pNREQ-1:0]        iv_Cyc,
  input  logic [pNREQ-1:0]        iv_Stb,
  input  logic [pNREQ-1:0]        iv_WnR,
  input  logic [32*pNREQ-1:0]     iv_WrData,
  input  logic [pADDRW*pNREQ-1:0] iv_Addr,
  input  logic [4*pNREQ-1:0]      iv_ByteEn,
  output logic [pNREQ-1:0]        ov_Ack,
  output logic [pNREQ-1:0]        ov_Err,
  output logic [31:0]             o32_RdData,
  output logic [pNREQ-1:0]        ov_Gnt,
  output logic                    o_SCyc,
  output logic                    o_SStb,
  output logic                    o_SWnR,
  output logic [31:0]             o32_SWrData,
  output logic [pADDRW-1:0]       ov_SAddr,
  output logic [3:0]              o4_SByteEn,
  input  logic                    i_SAck,
  input  logic [31:0]             i32_SRdData
);

  localparam int IW = idx_width(pNREQ);

  state_t             state_r;
  logic [pNREQ-1:0]   gnt_r;
  logic [IW-1:0]      gidx_r;
  logic [pNREQ-1:0]   req_s;
  logic [pNREQ-1:0]   arb_gnt_s;
  logic [IW-1:0]      arb_idx_s;
  logic               arb_update_s;
  logic               xfer_s;
  logic               g_cyc_s;
  logic               g_stb_s;
  logic               tmo_s;
  logic               g_wnr_s;
  logic [31:0]        g_wdata_s;
  logic [pADDRW-1:0]  g_addr_s;
  logic [3:0]         g_be_s;

  assign req_s        = iv_Cyc & iv_Stb;
  assign arb_update_s = (state_r == IDLE) && (|req_s);
  assign xfer_s       = (state_r == XFER);
  assign g_cyc_s      = iv_Cyc[gidx_r];
  assign g_stb_s      = iv_Stb[gidx_r];

  rr_arbiter #(.pNREQ(pNREQ)) u_rr (
    .clk     (i_Clk),
    .arst    (i_ARst),
    .req     (req_s),
    .update  (arb_update_s),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(pTIMEOUT + 1);
  logic [CW-1:0] cnt_r;

  assign tmo_s = xfer_s && !i_SAck && g_cyc_s && (cnt_r == CW'(pTIMEOUT - 1));

  // Counts XFER cycles; any other state clears it so each transfer starts at zero.
  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      cnt_r <= '0;
    end else if (state_r != XFER) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end
`else
  assign tmo_s = 1'b0;
`endif

  // AND-OR mux of the granted master's fields; all-zero while no grant is held.
  always_comb begin
    g_wnr_s   = 1'b0;
    g_wdata_s = 32'h0;
    g_addr_s  = '0;
    g_be_s    = 4'h0;
    for (int k = 0; k < pNREQ; k++) begin
      g_wnr_s   = g_wnr_s   | (iv_WnR[k] & gnt_r[k]);
      g_wdata_s = g_wdata_s | (iv_WrData[32*k +: 32] & {32{gnt_r[k]}});
      g_addr_s  = g_addr_s  | (iv_Addr[pADDRW*k +: pADDRW] & {pADDRW{gnt_r[k]}});
      g_be_s    = g_be_s    | (iv_ByteEn[4*k +: 4] & {4{gnt_r[k]}});
    end
  end

  // Arbitration FSM: IDLE picks a master, XFER runs one access, HOLD keeps a locked grant.
  always_ff @(posedge i_Clk or posedge i_ARst) begin
    if (i_ARst) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      gidx_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|req_s) begin
            state_r <= XFER;
            gnt_r   <= arb_gnt_s;
            gidx_r  <= arb_idx_s;
          end
        end
        XFER: begin
          if (i_SAck && g_cyc_s) begin
            state_r <= HOLD;
          end else if (i_SAck || !g_cyc_s || tmo_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
          end
        end
        HOLD: begin
          if (!g_cyc_s) begin
            state_r <= IDLE;
            gnt_r   <= '0;
          end else if (g_stb_s) begin
            state_r <= XFER;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= '0;
        end
      endcase
    end
  end

  assign ov_Gnt      = gnt_r;
  assign o_SCyc      = (state_r != IDLE);
  assign o_SStb      = xfer_s;
  assign o_SWnR      = g_wnr_s;
  assign o32_SWrData = g_wdata_s;
  assign ov_SAddr    = g_addr_s;
  assign o4_SByteEn  = g_be_s;
  // A real slave ack in the timeout cycle takes precedence over the error response.
  assign ov_Ack      = (xfer_s && (i_SAck || tmo_s)) ? gnt_r : '0;
  assign ov_Err      = tmo_s ? gnt_r : '0;
  assign o32_RdData  = (xfer_s && i_SAck) ? i32_SRdData : (tmo_s ? TIMEOUT_DATA : 32'h0);

endmodule

// File: tb/tb_wb_reg_arbiter.sv
// Directed bench for wb_reg_arbiter: vector table plus hand-written lock/abort/reset/timeout sequences.
module tb_wb_reg_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit ERR_OK = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit ERR_OK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      cyc, stb, wnr;
  logic [32*N-1:0]   wdata;
  logic [AW*N-1:0]   addr;
  logic [4*N-1:0]    be;
  logic [N-1:0]      ack, err, gnt;
  logic [31:0]       rdata;
  logic              scyc, sstb, swnr, sack;
  logic [31:0]       swdata, srdata;
  logic [AW-1:0]     saddr;
  logic [3:0]        sbe;
  logic              slave_en;
  logic [31:0]       mem [32];

  int checks = 0;
  int errors = 0;
  int got_q[$];

  always #5 clk = ~clk;

  wb_reg_arbiter #(.pNREQ(N), .pADDRW(AW), .pTIMEOUT(TMO)) dut (
    .i_Clk(clk), .i_ARst(rst),
    .iv_Cyc(cyc), .iv_Stb(stb), .iv_WnR(wnr), .iv_WrData(wdata), .iv_Addr(addr), .iv_ByteEn(be),
    .ov_Ack(ack), .ov_Err(err), .o32_RdData(rdata), .ov_Gnt(gnt),
    .o_SCyc(scyc), .o_SStb(sstb), .o_SWnR(swnr), .o32_SWrData(swdata), .ov_SAddr(saddr),
    .o4_SByteEn(sbe), .i_SAck(sack), .i32_SRdData(srdata)
  );

  // One-cycle register-bank slave with byte-enabled writes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sack   <= 1'b0;
      srdata <= 32'h0;
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else begin
      sack   <= scyc && sstb && !sack && slave_en;
      srdata <= mem[saddr];
      if (scyc && sstb && !sack && slave_en && swnr)
        for (int b = 0; b < 4; b++)
          if (sbe[b]) mem[saddr][8*b +: 8] <= swdata[8*b +: 8];
    end
  end

  typedef struct {
    int          m;
    logic        w;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    cyc[m] = c; stb[m] = s; wnr[m] = w;
    addr[AW*m +: AW] = a; wdata[32*m +: 32] = d; be[4*m +: 4] = b;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    set_m(v.m, 1'b1, 1'b1, v.w, v.a, v.d, v.b);
    @(negedge clk);
    chk("c0_scyc", 32'(scyc), 32'h0);
    chk("c0_saddr_zero", 32'(saddr), 32'h0);
    next_cycle(); @(negedge clk);
    chk("c1_sstb", 32'(sstb), 32'h1);
    chk("c1_gnt", 32'(gnt), 32'h1 << v.m);
    chk("c1_saddr", 32'(saddr), 32'(v.a));
    chk("c1_swdata", swdata, v.d);
    chk("c1_sbe_wnr", {27'h0, sbe, swnr}, {27'h0, v.b, v.w});
    chk("c1_no_ack", 32'(ack), 32'h0);
    next_cycle(); @(negedge clk);
    chk("c2_ack", 32'(ack), 32'h1 << v.m);
    if (!v.w) chk("c2_rdata", rdata, v.exp_rd);
    set_m(v.m, 1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    next_cycle();
  endtask

  task automatic serve(input logic [N-1:0] mask);
    int budget;
    for (int k = 0; k < N; k++)
      if (mask[k]) set_m(k, 1'b1, 1'b1, 1'b0, AW'(k + 1), 32'h0, 4'hF);
    budget = 0;
    while ((cyc != '0) && (budget < 50)) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (ack[k]) begin got_q.push_back(k); cyc[k] = 1'b0; stb[k] = 1'b0; end
      next_cycle();
      budget++;
    end
    chk("serve_done", 32'(cyc), 32'h0);
  endtask

  task automatic monitor();
    logic [N-1:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      checks++;
      if (((ack & ~gnt) != '0) || ((err & ~(ERR_OK ? ack : '0)) != '0) ||
          ((prev_gnt != '0) && (gnt != '0) && (gnt != prev_gnt))) begin
        errors++;
        $display("FAIL monitor: ack %b err %b gnt %b prev_gnt %b", ack, err, gnt, prev_gnt);
      end
      prev_gnt = gnt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n0, ack_c;
    logic hold_ok, ack_err, scyc_after;
    logic [31:0] rd0, ack_rd;

    vec[0] = '{0, 1'b1, 5'd3,  32'h12345678, 4'hF,    32'h0};
    vec[1] = '{0, 1'b0, 5'd3,  32'h0,        4'hF,    32'h12345678};
    vec[2] = '{1, 1'b1, 5'd5,  32'hAABBCCDD, 4'hF,    32'h0};
    vec[3] = '{1, 1'b1, 5'd5,  32'h11223344, 4'b0101, 32'h0};
    vec[4] = '{0, 1'b0, 5'd5,  32'h0,        4'hF,    32'hAA22CC44};
    vec[5] = '{1, 1'b1, 5'd31, 32'hCAFEF00D, 4'b1000, 32'h0};
    vec[6] = '{0, 1'b0, 5'd0,  32'h0,        4'hF,    32'h0};
    vec[7] = '{1, 1'b0, 5'd31, 32'h0,        4'hF,    32'hCA000000};

    rst = 1'b1; cyc = '0; stb = '0; wnr = '0; wdata = '0; addr = '0; be = '0; slave_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_scyc_sstb", {30'h0, scyc, sstb}, 32'h0);
    chk("rst_ack_rdata", rdata | 32'(ack), 32'h0);
    fork monitor(); join_none
    next_cycle();

    for (int i = 0; i < 8; i++) run_vec(vec[i]);

    // Contention: pointer is at master 1, so two rounds give 0,1,0,1.
    got_q.delete();
    serve(2'b11);
    serve(2'b11);
    chk("rr_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (got_q.size() > i) ? 32'(got_q[i]) : 32'hFFFFFFFF, 32'(i % 2));

    // Locked cycle: master 1 keeps Cyc through 3 strobes while master 0 waits.
    set_m(1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000BEEF, 4'hF);
    n1 = 0; n0 = 0; hold_ok = 1'b1; rd0 = 32'h0;
    for (int c = 0; (c < 60) && (cyc != '0); c++) begin
      @(negedge clk);
      if (c == 1) set_m(0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0, 4'hF);
      if ((c >= 1) && cyc[1] && ((gnt != 2'b10) || !scyc)) hold_ok = 1'b0;
      if (ack[0]) begin
        if (n1 < 3) hold_ok = 1'b0;
        n0++; rd0 = rdata; cyc[0] = 1'b0; stb[0] = 1'b0;
      end
      if (ack[1]) begin
        n1++;
        if (n1 == 3) begin cyc[1] = 1'b0; stb[1] = 1'b0; end
      end
      next_cycle();
    end
    chk("hold_m1_acks", 32'(n1), 32'd3);
    chk("hold_m0_acks", 32'(n0), 32'd1);
    chk("hold_grant_kept", 32'(hold_ok), 32'h1);
    chk("hold_m0_rdata", rd0, 32'h0000BEEF);

    // Abort: master 0 drops Cyc in XFER; the late slave ack must be discarded.
    set_m(0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 4'hF);
    @(negedge clk); next_cycle(); @(negedge clk);
    chk("abort_c1_gnt", 32'(gnt), 32'h1);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    next_cycle(); @(negedge clk);
    chk("abort_no_ack", 32'(ack), 32'h0);
    chk("abort_idle", {30'h0, scyc, |gnt}, 32'h0);
    next_cycle();
    got_q.delete();
    serve(2'b10);
    chk("abort_m1_served", (got_q.size() == 1) ? 32'(got_q[0]) : 32'hFFFFFFFF, 32'd1);

    // Reset mid-XFER after granting master 0; pointer must return to master 1.
    set_m(0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0, 4'hF);
    @(negedge clk); next_cycle(); @(negedge clk);
    chk("rstx_pre_gnt", 32'(gnt), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstx_gnt", 32'(gnt), 32'h0);
    chk("rstx_scyc_ack", {30'h0, scyc, |ack}, 32'h0);
    #1 rst = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    next_cycle();
    got_q.delete();
    serve(2'b11);
    chk("rstx_first", (got_q.size() == 2) ? 32'(got_q[0]) : 32'hFFFFFFFF, 32'd0);

    // Silent slave: timeout response when enabled, otherwise an indefinite wait.
    slave_en = 1'b0;
    ack_c = -1; ack_err = 1'b0; ack_rd = 32'h0; scyc_after = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 4'hF);
    for (int c = 0; c < (ERR_OK ? TMO + 3 : 300); c++) begin
      @(negedge clk);
      if ((ack_c >= 0) && (c == ack_c + 1)) scyc_after = scyc;
      if (ack[0] && (ack_c < 0)) begin
        ack_c = c; ack_err = err[0]; ack_rd = rdata;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
      end
      next_cycle();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("tmo_ack_cycle", 32'(ack_c), 32'(TMO));
    chk("tmo_err", 32'(ack_err), 32'h1);
    chk("tmo_rdata", ack_rd, 32'hDEADBEEF);
    chk("tmo_then_idle", 32'(scyc_after), 32'h0);
`else
    chk("wait_no_ack", 32'(ack_c), 32'hFFFFFFFF);
    @(negedge clk);
    chk("wait_still_xfer", {30'h0, scyc, sstb}, 32'h3);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    next_cycle(); @(negedge clk);
    chk("wait_abort_idle", 32'(scyc), 32'h0);
`endif
    slave_en = 1'b1;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_arbiter.md
Name: wb_reg_arbiter

Overview:
Round-robin Wishbone arbiter that shares one register-bank slave between pNREQ requesters, for example the PCIe TLP handler and the local management CPU. It grants one master at a time and forwards that master's cycle to the slave. It returns the slave ack and read data to the granted master only, and can hold the grant across a locked multi-access cycle.

Parameters:
pNREQ, 2, number of requesters (2..8)
pADDRW, 5, slave word-address width
pTIMEOUT, 255, max cycles to wait for slave ack (used only with the optional feature)

Ports:
i_Clk  in  1  clock
i_ARst  in  1  reset, asynchronous, active-high
iv_Cyc  in  pNREQ  per-master WB cycle
iv_Stb  in  pNREQ  per-master WB strobe
iv_WnR  in  pNREQ  per-master write(1)/read(0)
iv_WrData  in  32*pNREQ  per-master write data, master k at [32k+31:32k]
iv_Addr  in  pADDRW*pNREQ  per-master address
iv_ByteEn  in  4*pNREQ  per-master byte enables
ov_Ack  out  pNREQ  per-master ack pulse
ov_Err  out  pNREQ  per-master error pulse, asserted with ack
o32_RdData  out  32  read data, valid with any ack
ov_Gnt  out  pNREQ  one-hot current grant, 0 when idle
o_SCyc, o_SStb, o_SWnR  out  1 each  slave control
o32_SWrData  out  32  slave write data
ov_SAddr  out  pADDRW  slave address
o4_SByteEn  out  4  slave byte enables
i_SAck  in  1  slave ack
i32_SRdData  in  32  slave read data

Behaviour:
- Reset: state IDLE, ov_Gnt=0, last-grant pointer=pNREQ-1 (so master 0 wins first), all outputs 0.
- States:
  - IDLE: request k means iv_Cyc[k]&iv_Stb[k]. If any request is present, pick the first requester after the last-grant pointer (circular), register ov_Gnt, update the pointer, go to XFER. Otherwise stay in IDLE.
  - XFER: o_SCyc=o_SStb=1 and the slave buses carry the granted master's fields.
    - On i_SAck: ov_Ack[g]=i_SAck (same cycle), o32_RdData=i32_SRdData. Go to HOLD if iv_Cyc[g]=1, else IDLE.
    - If iv_Cyc[g] drops before ack: abort to IDLE. A late i_SAck is discarded and no ack is issued.
  - HOLD (locked cycle): o_SCyc=1, o_SStb=0.
    - iv_Stb[g]=1 goes to XFER on the next edge with no re-arbitration.
    - iv_Cyc[g]=0 goes to IDLE.
    - Other masters wait while HOLD lasts.
- Slave address, data and byte-enable outputs are forced to 0 when no grant is held.
- Latency: request sampled at edge 0, slave strobe visible in cycle 1. With the one-cycle slave this gives ack in cycle 2.
- ov_Ack and ov_Err are combinational from i_SAck and state. They are never asserted to a non-granted master.
- Fairness: with all masters requesting continuously, grants rotate 0,1,..,pNREQ-1,0.
- Simultaneous events: a request arriving while i_SAck ends a non-locked transfer is arbitrated in the following IDLE cycle. The arbiter always spends one IDLE cycle between different masters.
- Reset mid-transfer: everything clears immediately and no ack is issued.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Defined: a counter clears on entering XFER and increments each XFER cycle. If it reaches pTIMEOUT with no i_SAck:
  - ov_Ack[g]=ov_Err[g]=1 for one cycle, o32_RdData=32'hDEADBEEF;
  - o_SStb and o_SCyc drop, go to IDLE.
  - An i_SAck on the same cycle as the timeout wins: normal ack, no error.
- Undefined: no counter, ov_Err tied 0, and XFER waits indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum IDLE/XFER/HOLD;
  - constant TIMEOUT_DATA=32'hDEADBEEF;
  - width helper for the grant index, clog2(pNREQ).
- One sub-module, rr_arbiter: takes a request vector and the last-grant pointer, and returns a one-hot grant plus its index. It is combinational apart from the pointer register.

Test Plan:
- Single master 0 write addr 3 data 32'h12345678 byteen 4'hF -> o_SStb high cycle 1, ov_Ack[0] cycle 2, later read of addr 3 returns 32'h12345678.
- Masters 0 and 1 request the same cycle, repeated 4 times -> grant order 0,1,0,1, exactly one ack per access, no ack to the non-granted master.
- Master 1 holds iv_Cyc through 3 strobes while master 0 requests -> master 1 gets 3 acks back-to-back via HOLD, master 0 granted only after iv_Cyc[1] drops.
- Master 0 drops iv_Cyc in XFER before ack -> IDLE next cycle, no ov_Ack[0], master 1 then served normally.
- i_ARst pulsed mid-XFER -> ov_Gnt=0, o_SCyc=0 immediately; next request from master 0 is granted first.
- With WB_ARB_TIMEOUT_EN and pTIMEOUT=4, slave never acks -> ov_Ack[0]=ov_Err[0]=1 in the 4th XFER cycle with o32_RdData=32'hDEADBEEF, then IDLE.
